// File: rtl/sram_bus_responder_if.sv
// SLC-3 external SRAM bus control/address signals (all active-low strobes).
// The bidirectional Data lines stay a plain inout on the responder.
interface sram_bus_responder_if;
   logic        CE;
   logic        UB;
   logic        LB;
   logic        OE;
   logic        WE;
   logic [19:0] ADDR;

   modport master (output CE, UB, LB, OE, WE, ADDR);
   modport slave  (input  CE, UB, LB, OE, WE, ADDR);
endinterface

// File: rtl/sram_bus_responder.sv
// Synthesizable stand-in for the SLC-3 external SRAM: answers the memory bus
// from an on-chip word array with READ_LAT read wait states. Clears the array
// after reset; writes commit when the write strobe is released.
module sram_bus_responder #(
   parameter int unsigned ADDR_W   = 10,
   parameter int unsigned READ_LAT = 2
) (
   input  logic                 Clk,
   input  logic                 Reset,
   sram_bus_responder_if.slave  bus,
   inout  wire  [15:0]          Data,
   output logic                 Init_Done,
   output logic                 Rd_Valid
);

   localparam int unsigned Depth = 1 << ADDR_W;

   typedef enum logic [2:0] {StInit, StIdle, StReadWait, StReadDrive, StWrite} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [3:0]        wait_cnt_q, wait_cnt_d;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [15:0]       wr_data_q;
   logic              wr_ub_q, wr_lb_q;

   logic [15:0]       mem [Depth];

   logic              rd_cond, wr_cond, drive_en;
   logic [ADDR_W-1:0] bus_addr;
   logic [15:0]       rd_word;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [15:0]       mem_wdata;
   logic [1:0]        mem_wbe;
   logic              unused_addr;

   // Upper address bits alias onto the array.
   assign unused_addr = ^bus.ADDR;
   assign bus_addr    = bus.ADDR[ADDR_W-1:0];
   assign rd_cond     = !bus.CE && !bus.OE && bus.WE;
   assign wr_cond     = !bus.CE && !bus.WE;

   // Drive is gated combinationally so OE/CE/WE release the bus in the same cycle.
   assign drive_en  = (state_q == StReadDrive) && rd_cond && !Reset;
   assign rd_word   = mem[rd_addr_q];
   assign Rd_Valid  = drive_en;
   assign Init_Done = (state_q != StInit) && !Reset;
   assign Data[15:8] = (drive_en && !bus.UB) ? rd_word[15:8] : 8'hzz;
   assign Data[7:0]  = (drive_en && !bus.LB) ? rd_word[7:0]  : 8'hzz;

   // State and counters; reset restarts clearing and drops any pending write.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= StInit;
         clr_cnt_q  <= '0;
         rd_addr_q  <= '0;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_cnt_q  <= clr_cnt_d;
         rd_addr_q  <= rd_addr_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // Capture write address/data/lanes every cycle the write strobe is held; last wins.
   always_ff @(posedge Clk) begin
      if (wr_cond) begin
         wr_addr_q <= bus_addr;
         wr_data_q <= Data;
         wr_ub_q   <= bus.UB;
         wr_lb_q   <= bus.LB;
      end
   end

   // Next-state logic and the single array write port (clear or commit).
   always_comb begin
      state_d    = state_q;
      clr_cnt_d  = clr_cnt_q;
      rd_addr_d  = rd_addr_q;
      wait_cnt_d = wait_cnt_q;
      mem_we     = 1'b0;
      mem_waddr  = wr_addr_q;
      mem_wdata  = wr_data_q;
      mem_wbe    = {~wr_ub_q, ~wr_lb_q};
      unique case (state_q)
         StInit: begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt_q;
            mem_wdata = 16'h0000;
            mem_wbe   = 2'b11;
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == {ADDR_W{1'b1}}) state_d = StIdle;
         end
         StIdle: begin
            if (wr_cond) begin
               state_d = StWrite;
            end else if (rd_cond) begin
               state_d    = StReadWait;
               rd_addr_d  = bus_addr;
               wait_cnt_d = 4'd1;
            end
         end
         StReadWait: begin
            if (wr_cond) begin
               state_d = StWrite;
            end else if (!rd_cond) begin
               state_d = StIdle;
            end else if (bus_addr != rd_addr_q) begin
               rd_addr_d  = bus_addr;
               wait_cnt_d = 4'd1;
            end else if (wait_cnt_q == 4'(READ_LAT)) begin
               state_d = StReadDrive;
            end else begin
               wait_cnt_d = wait_cnt_q + 4'd1;
            end
         end
         StReadDrive: begin
            if (wr_cond) begin
               state_d = StWrite;
            end else if (!rd_cond) begin
               state_d = StIdle;
            end else if (bus_addr != rd_addr_q) begin
               state_d    = StReadWait;
               rd_addr_d  = bus_addr;
               wait_cnt_d = 4'd1;
            end
         end
         StWrite: begin
            if (!wr_cond) begin
               mem_we = 1'b1;
               if (rd_cond) begin
                  state_d    = StReadWait;
                  rd_addr_d  = bus_addr;
                  wait_cnt_d = 4'd1;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StInit;
      endcase
   end

   // Byte-lane array write; suppressed while reset is asserted.
   always_ff @(posedge Clk) begin
      if (mem_we && !Reset) begin
         if (mem_wbe[1]) mem[mem_waddr][15:8] <= mem_wdata[15:8];
         if (mem_wbe[0]) mem[mem_waddr][7:0]  <= mem_wdata[7:0];
      end
   end

endmodule

// File: tb/tb_sram_bus_responder.sv
// Bench for sram_bus_responder: directed scenarios plus random reads/writes
// checked against a word-array model. Data has a pull-up, so released lanes read 1s.
module tb_sram_bus_responder;
   localparam int unsigned AW    = 4;
   localparam int unsigned LAT   = 2;
   localparam int unsigned DEPTH = 1 << AW;

   logic clk = 1'b0;
   logic rst;
   logic init_done, rd_valid;
   logic tb_drv;
   logic [15:0] tb_wdata;
   tri1 [15:0] data_bus;

   int checks   = 0;
   int failures = 0;
   logic [15:0] model [DEPTH];

   always #5 clk = ~clk;

   sram_bus_responder_if bus_if ();

   assign data_bus = tb_drv ? tb_wdata : 16'hzzzz;

   sram_bus_responder #(.ADDR_W(AW), .READ_LAT(LAT)) dut (
      .Clk       (clk),
      .Reset     (rst),
      .bus       (bus_if.slave),
      .Data      (data_bus),
      .Init_Done (init_done),
      .Rd_Valid  (rd_valid)
   );

   task automatic bus_idle();
      bus_if.CE = 1'b1; bus_if.OE = 1'b1; bus_if.WE = 1'b1;
      bus_if.UB = 1'b1; bus_if.LB = 1'b1; tb_drv = 1'b0;
   endtask

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) model[i] = 16'h0000;
   endtask

   // Counts edges from reset release until Init_Done; checks length and a silent bus.
   task automatic wait_init(input bit inject, input string tag);
      int edges = 0;
      bit seen  = 0;
      bit quiet = 1;
      while (!seen && edges < 4 * DEPTH) begin
         if (inject && edges == 2) begin
            bus_if.CE = 1'b0; bus_if.WE = 1'b0; bus_if.UB = 1'b0; bus_if.LB = 1'b0;
            bus_if.ADDR = 20'h00007; tb_wdata = 16'hABCD; tb_drv = 1'b1;
         end
         if (inject && edges == 3) bus_idle();
         @(negedge clk);
         edges++;
         if (rd_valid !== 1'b0 || (!tb_drv && data_bus !== 16'hFFFF)) quiet = 0;
         if (init_done === 1'b1) seen = 1;
      end
      checks++;
      if (!seen || edges != DEPTH) begin
         failures++;
         $display("FAIL %s init_len: done=%0b after %0d edges, required done after %0d",
                  tag, seen, edges, DEPTH);
      end
      checks++;
      if (!quiet) begin
         failures++;
         $display("FAIL %s init_quiet: bus driven during init, required high-Z", tag);
      end
   endtask

   // Write transaction: ncyc cycles of WE low (earlier cycles carry junk), leaves
   // the bus idle at the start of the commit cycle.
   task automatic do_write(input logic [19:0] addr, input logic [15:0] data, input logic ub,
                           input logic lb, input int ncyc, input string tag);
      logic [AW-1:0] idx;
      for (int i = 0; i < ncyc; i++) begin
         bus_if.CE = 1'b0; bus_if.WE = 1'b0; bus_if.OE = 1'($urandom); tb_drv = 1'b1;
         if (i == ncyc - 1) begin
            bus_if.ADDR = addr; tb_wdata = data; bus_if.UB = ub; bus_if.LB = lb;
         end else begin
            bus_if.ADDR = 20'($urandom); tb_wdata = 16'($urandom);
            bus_if.UB = 1'($urandom); bus_if.LB = 1'($urandom);
         end
         @(negedge clk);
         checks++;
         if (rd_valid !== 1'b0 || data_bus !== tb_wdata) begin
            failures++;
            $display("FAIL %s write_no_drive: rd_valid=%b data=%h, required 0 / %h",
                     tag, rd_valid, data_bus, tb_wdata);
         end
      end
      idx = addr[AW-1:0];
      if (!ub) model[idx][15:8] = data[15:8];
      if (!lb) model[idx][7:0]  = data[7:0];
      bus_if.WE = 1'b1; bus_if.CE = 1'b1; bus_if.OE = 1'b1; tb_drv = 1'b0;
   endtask

   // Read transaction: LAT silent cycles, hold valid cycles, immediate release, one idle.
   task automatic do_read(input logic [19:0] addr, input logic ub, input logic lb,
                          input int hold, input string tag);
      logic [15:0] w, exp;
      w   = model[addr[AW-1:0]];
      exp = {ub ? 8'hFF : w[15:8], lb ? 8'hFF : w[7:0]};
      bus_if.CE = 1'b0; bus_if.OE = 1'b0; bus_if.WE = 1'b1;
      bus_if.ADDR = addr; bus_if.UB = ub; bus_if.LB = lb; tb_drv = 1'b0;
      for (int i = 0; i < LAT; i++) begin
         @(negedge clk);
         checks++;
         if (rd_valid !== 1'b0 || data_bus !== 16'hFFFF) begin
            failures++;
            $display("FAIL %s read_wait@%h: rd_valid=%b data=%h, required 0 / ffff",
                     tag, addr, rd_valid, data_bus);
         end
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         checks++;
         if (rd_valid !== 1'b1 || data_bus !== exp) begin
            failures++;
            $display("FAIL %s read_data@%h: rd_valid=%b data=%h, required 1 / %h",
                     tag, addr, rd_valid, data_bus, exp);
         end
      end
      bus_if.OE = 1'b1; bus_if.CE = 1'b1;
      #1;
      checks++;
      if (rd_valid !== 1'b0 || data_bus !== 16'hFFFF) begin
         failures++;
         $display("FAIL %s read_release: rd_valid=%b data=%h, required 0 / ffff",
                  tag, rd_valid, data_bus);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      bus_idle();
      bus_if.ADDR = '0; tb_wdata = '0;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (init_done !== 1'b0 || rd_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs: init_done=%b rd_valid=%b, required 0 / 0",
                  init_done, rd_valid);
      end
      rst = 1'b0;
      wait_init(1'b1, "reset");
      model_clear();
      for (int a = 0; a < DEPTH; a++) do_read(20'(a), 1'b0, 1'b0, 1, "reset_clear");
   endtask

   task automatic test_word_rw();
      do_write(20'h00012, 16'h3A5C, 1'b0, 1'b0, 1, "word");
      @(negedge clk);
      do_read(20'h00012, 1'b0, 1'b0, 2, "word");
      do_read(20'h000F2, 1'b0, 1'b0, 1, "alias");
   endtask

   task automatic test_byte_lanes();
      do_write(20'h00005, 16'hFFFF, 1'b0, 1'b0, 1, "lanes_full");
      @(negedge clk);
      do_write(20'h00005, 16'h1200, 1'b0, 1'b1, 1, "lanes_upper");
      @(negedge clk);
      checks++;
      if (model[5] !== 16'h12FF) begin
         failures++;
         $display("FAIL lanes_model: model=%h, required 12ff", model[5]);
      end
      do_read(20'h00005, 1'b1, 1'b0, 1, "lanes_ub_off");
      do_read(20'h00005, 1'b0, 1'b0, 1, "lanes_both");
   endtask

   task automatic test_addr_change();
      bus_if.CE = 1'b0; bus_if.OE = 1'b0; bus_if.WE = 1'b1;
      bus_if.UB = 1'b0; bus_if.LB = 1'b0; bus_if.ADDR = 20'h00005;
      repeat (LAT) @(negedge clk);
      @(negedge clk);
      checks++;
      if (rd_valid !== 1'b1 || data_bus !== 16'h12FF) begin
         failures++;
         $display("FAIL addr_first: rd_valid=%b data=%h, required 1 / 12ff", rd_valid, data_bus);
      end
      bus_if.ADDR = 20'h00012;
      for (int i = 0; i < LAT; i++) begin
         @(negedge clk);
         checks++;
         if (rd_valid !== 1'b0 || data_bus !== 16'hFFFF) begin
            failures++;
            $display("FAIL addr_gap%0d: rd_valid=%b data=%h, required 0 / ffff",
                     i, rd_valid, data_bus);
         end
      end
      @(negedge clk);
      checks++;
      if (rd_valid !== 1'b1 || data_bus !== 16'h3A5C) begin
         failures++;
         $display("FAIL addr_second: rd_valid=%b data=%h, required 1 / 3a5c", rd_valid, data_bus);
      end
      bus_if.OE = 1'b1;
      #1;
      checks++;
      if (rd_valid !== 1'b0 || data_bus !== 16'hFFFF) begin
         failures++;
         $display("FAIL addr_oe_release: rd_valid=%b data=%h, required 0 / ffff",
                  rd_valid, data_bus);
      end
      bus_idle();
      @(negedge clk);
   endtask

   task automatic test_we_oe_conflict();
      bus_if.CE = 1'b0; bus_if.OE = 1'b0; bus_if.WE = 1'b0;
      bus_if.UB = 1'b0; bus_if.LB = 1'b0; bus_if.ADDR = 20'h00009;
      tb_wdata = 16'hBEEF; tb_drv = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (rd_valid !== 1'b0 || data_bus !== 16'hBEEF) begin
            failures++;
            $display("FAIL conflict_no_drive: rd_valid=%b data=%h, required 0 / beef",
                     rd_valid, data_bus);
         end
      end
      model[9] = 16'hBEEF;
      bus_if.WE = 1'b1; tb_drv = 1'b0;
      for (int i = 0; i < LAT; i++) begin
         @(negedge clk);
         checks++;
         if (rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL conflict_wait: rd_valid=%b, required 0", rd_valid);
         end
      end
      @(negedge clk);
      checks++;
      if (rd_valid !== 1'b1 || data_bus !== 16'hBEEF) begin
         failures++;
         $display("FAIL conflict_read: rd_valid=%b data=%h, required 1 / beef", rd_valid, data_bus);
      end
      bus_idle();
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      do_write(20'h0000A, 16'h1357, 1'b0, 1'b0, 1, "b2b_a");
      do_read(20'h0000A, 1'b0, 1'b0, 1, "b2b_read_same_cycle");
      do_write(20'h0000B, 16'h2468, 1'b0, 1'b0, 3, "b2b_b");
      @(negedge clk);
      do_write(20'h0000C, 16'h9ACE, 1'b0, 1'b0, 1, "b2b_c");
      @(negedge clk);
      do_read(20'h0000B, 1'b0, 1'b0, 1, "b2b_b");
      do_read(20'h0000C, 1'b0, 1'b0, 1, "b2b_c");
   endtask

   task automatic test_random();
      for (int it = 0; it < 60; it++) begin
         logic [19:0] addr;
         addr = 20'($urandom);
         if ($urandom_range(0, 2) == 0) begin
            do_write(addr, 16'($urandom), 1'($urandom), 1'($urandom),
                     int'($urandom_range(1, 3)), "rand_wr");
            if ($urandom_range(0, 1) == 1)
               do_read(addr, 1'($urandom), 1'($urandom), 1, "rand_chain");
            else
               @(negedge clk);
         end else begin
            do_read(addr, 1'($urandom), 1'($urandom), int'($urandom_range(1, 3)), "rand_rd");
         end
      end
   endtask

   task automatic test_reset_mid_write();
      bus_if.CE = 1'b0; bus_if.WE = 1'b0; bus_if.OE = 1'b1;
      bus_if.UB = 1'b0; bus_if.LB = 1'b0; bus_if.ADDR = 20'h00003;
      tb_wdata = 16'h7777; tb_drv = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (init_done !== 1'b0) begin
         failures++;
         $display("FAIL midwr_reset: init_done=%b, required 0", init_done);
      end
      rst = 1'b0;
      bus_idle();
      wait_init(1'b0, "midwr");
      model_clear();
      do_read(20'h00003, 1'b0, 1'b0, 1, "midwr_lost");
      do_read(20'h00012, 1'b0, 1'b0, 1, "midwr_cleared");
   endtask

   initial begin
      model_clear();
      test_reset();
      test_word_rw();
      test_byte_lanes();
      test_addr_change();
      test_we_oe_conflict();
      test_back_to_back();
      test_random();
      test_reset_mid_write();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
